// File: rtl/spi_loopback_arbiter_if.sv
// Handshake bundle between NREQS requesters, the arbiter and the shared downstream unit.
// slave: arbiter side. master: requesters + shared unit side.
interface spi_loopback_arbiter_if #(
    parameter int unsigned nbits = 32,
    parameter int unsigned nreqs = 2
);
    logic [nreqs-1:0]       recv_val;
    logic [nreqs-1:0]       recv_rdy;
    logic [nreqs*nbits-1:0] recv_msg;
    logic [nreqs-1:0]       send_val;
    logic [nreqs-1:0]       send_rdy;
    logic [nreqs*nbits-1:0] send_msg;
    logic                   dn_req_val;
    logic                   dn_req_rdy;
    logic [nbits-1:0]       dn_req_msg;
    logic                   dn_resp_val;
    logic                   dn_resp_rdy;
    logic [nbits-1:0]       dn_resp_msg;

    modport slave (
        input  recv_val, recv_msg, send_rdy, dn_req_rdy, dn_resp_val, dn_resp_msg,
        output recv_rdy, send_val, send_msg, dn_req_val, dn_req_msg, dn_resp_rdy
    );

    modport master (
        output recv_val, recv_msg, send_rdy, dn_req_rdy, dn_resp_val, dn_resp_msg,
        input  recv_rdy, send_val, send_msg, dn_req_val, dn_req_msg, dn_resp_rdy
    );
endinterface

// File: rtl/spi_loopback_arbiter.sv
// Round-robin arbiter sharing one val/rdy unit between nreqs requesters. Grants lock until
// they transfer; an in-order ID FIFO routes each response back to its issuer.
// Optional macro SPI_V3_ARB_FIXED_PRIO_EN: fixed priority (lowest valid index wins).
module spi_loopback_arbiter #(
    parameter int unsigned nbits           = 32,
    parameter int unsigned nreqs           = 2,
    parameter int unsigned max_outstanding = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    spi_loopback_arbiter_if.slave  bus,
    output logic                   orphan_err
);
    localparam int unsigned IdW  = (nreqs > 1) ? $clog2(nreqs) : 1;
    localparam int unsigned PtrW = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
    localparam int unsigned CntW = $clog2(max_outstanding + 1);

    typedef logic [IdW-1:0] id_t;
    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e          state_q;
    id_t             gnt_q;
    id_t             rr_ptr_q;
    logic [PtrW-1:0] head_q;
    logic [PtrW-1:0] tail_q;
    logic [CntW-1:0] count_q;
    id_t             id_mem_q [max_outstanding];
    logic            orphan_q;

    id_t  cand;
    logic cand_vld;
    id_t  win_id;
    id_t  next_rr;
    id_t  head_id;
    logic req_val;
    logic req_fire;
    logic resp_rdy;
    logic resp_fire;
    logic full;
    logic empty;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(max_outstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CntW'(max_outstanding));
    assign empty   = (count_q == '0);
    assign head_id = id_mem_q[head_q];

    // First valid requester at or after rr_ptr, wrapping around
    always_comb begin
        int unsigned idx;
        idx      = 0;
        cand     = '0;
        cand_vld = 1'b0;
        for (int unsigned k = 0; k < nreqs; k++) begin
            idx = (32'(rr_ptr_q) + k) % nreqs;
            if (!cand_vld && bus.recv_val[idx]) begin
                cand_vld = 1'b1;
                cand     = id_t'(idx);
            end
        end
    end

    // Request winner: fresh candidate when idle, the locked grant otherwise
    always_comb begin
        req_val = 1'b0;
        win_id  = cand;
        case (state_q)
            StIdle: begin
                req_val = cand_vld && !full;
                win_id  = cand;
            end
            StLocked: begin
                // A dropped val in LOCKED aborts the grant without a transfer
                req_val = bus.recv_val[gnt_q];
                win_id  = gnt_q;
            end
            default: ;
        endcase
    end

    assign req_fire = req_val && bus.dn_req_rdy && !reset;

`ifdef SPI_V3_ARB_FIXED_PRIO_EN
    assign next_rr = '0;
`else
    assign next_rr = (32'(win_id) == nreqs - 1) ? '0 : win_id + 1'b1;
`endif

    // Request path outputs, forced to 0 during reset
    always_comb begin
        bus.recv_rdy   = '0;
        bus.dn_req_val = 1'b0;
        bus.dn_req_msg = '0;
        if (!reset && req_val) begin
            bus.dn_req_val       = 1'b1;
            bus.dn_req_msg       = bus.recv_msg[32'(win_id) * nbits +: nbits];
            bus.recv_rdy[win_id] = bus.dn_req_rdy;
        end
    end

    // Response routing to the FIFO head; an empty FIFO drains orphaned responses
    always_comb begin
        bus.send_val = '0;
        bus.send_msg = '0;
        resp_rdy     = 1'b0;
        if (!reset) begin
            bus.send_msg = {nreqs{bus.dn_resp_msg}};
            if (!empty) begin
                bus.send_val[head_id] = bus.dn_resp_val;
                resp_rdy              = bus.send_rdy[head_id];
            end else begin
                resp_rdy = 1'b1;
            end
        end
    end

    assign bus.dn_resp_rdy = resp_rdy;
    assign resp_fire       = !empty && bus.dn_resp_val && resp_rdy;
    assign orphan_err      = orphan_q && !reset;

    // Request FSM, round-robin pointer, ID FIFO and sticky orphan flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
            for (int i = 0; i < int'(max_outstanding); i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (cand_vld && !full && !bus.dn_req_rdy) begin
                        state_q <= StLocked;
                        gnt_q   <= cand;
                    end
                end
                StLocked: begin
                    if (req_fire || !bus.recv_val[gnt_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            if (req_fire) begin
                id_mem_q[tail_q] <= win_id;
                tail_q           <= ptr_inc(tail_q);
                rr_ptr_q         <= next_rr;
            end
            if (resp_fire) begin
                head_q <= ptr_inc(head_q);
            end
            case ({req_fire, resp_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (empty && bus.dn_resp_val) begin
                orphan_q <= 1'b1;
            end
        end
    end
endmodule
